// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter slice.
// Included by the arbiter top and by its wait-state counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  localparam int DEF_WAIT          = 1;
  localparam int DEF_MAX_CPU_BURST = 4;

  // Counter widths cover the full legal ranges (WAIT 0..7, burst cap 1..15).
  localparam int WAIT_CW  = 3;
  localparam int BURST_CW = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU, the debug loader, the arbiter and external memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/wait_state_counter.sv
// Dwell counter for the ACCESS state: counts 0..WAIT and flags the last cycle.
module wait_state_counter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = DEF_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WAIT_CW-1:0] LAST = WAIT_CW'(WAIT);

  logic [WAIT_CW-1:0] count;

  assign terminal = (count == LAST);

  // Holds at LAST so a stalled enable cannot wrap past the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + WAIT_CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory port between the CPU sequencer and the debug loader.
// CPU has priority; a burst cap hands the port to the loader after MAX_CPU_BURST grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 8,
  parameter int DW            = 8,
  parameter int WAIT          = DEF_WAIT,
  parameter int MAX_CPU_BURST = DEF_MAX_CPU_BURST
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [BURST_CW-1:0] BURST_MAX = BURST_CW'(MAX_CPU_BURST);

  state_t              state;
  owner_t              owner;
  logic [BURST_CW-1:0] burst_cnt;
  logic                wait_done;
  logic                cpu_win;
  logic                dbg_win;
  logic                grant_we;
  logic [AW-1:0]       grant_addr;
  logic [DW-1:0]       grant_wdata;

  wait_state_counter #(
    .WAIT(WAIT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ACCESS),
    .enable  (state == ACCESS),
    .terminal(wait_done)
  );

  // Loader only beats a requesting CPU once the CPU has used up its burst allowance.
  assign cpu_win = bus.cpu_req && (!bus.dbg_req || (burst_cnt != BURST_MAX));
  assign dbg_win = bus.dbg_req && !cpu_win;

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

  always_comb begin
    grant_we    = bus.cpu_we;
    grant_addr  = bus.cpu_addr;
    grant_wdata = bus.cpu_wdata;
    if (!cpu_win) begin
      grant_we    = bus.dbg_we;
      grant_addr  = bus.dbg_addr;
      grant_wdata = bus.dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      burst_cnt     <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dbg_win || !bus.dbg_req) begin
            burst_cnt <= '0;
          end else if (cpu_win && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + BURST_CW'(1);
          end
          if (cpu_win || dbg_win) begin
            if (cpu_win) begin
              owner <= OWN_CPU;
            end else begin
              owner <= OWN_DBG;
            end
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_we;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= grant_wdata;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack is registered here so it is high for exactly the DONE cycle.
          if (wait_done) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= DONE;
            if (owner == OWN_CPU) begin
              bus.cpu_ack <= 1'b1;
              if (!bus.mem_we) begin
                bus.cpu_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.dbg_ack <= 1'b1;
              if (!bus.mem_we) begin
                bus.dbg_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
